// File: rtl/sbox_pkg.sv
// Shared state encoding and sizing constants for the S-box builder.
package sbox_pkg;

  localparam int unsigned SBOX_SIZE = 256;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned COUNT_W   = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/sbox_mem.sv
// 256x8 register file: synchronous write, asynchronous read, async clear to zero.
module sbox_mem
  import sbox_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [BYTE_W-1:0] wr_addr,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic [BYTE_W-1:0] rd_addr,
  output logic [BYTE_W-1:0] rd_data
);

  logic [BYTE_W-1:0] mem [SBOX_SIZE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SBOX_SIZE; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sbox_builder.sv
// Builds a byte permutation from a stream of candidate bytes, rejecting repeats.
// Define SBOX_BUILDER_INV_EN to also build the inverse table.
module sbox_builder
  import sbox_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               cand_valid,
  input  logic [BYTE_W-1:0]  cand_byte,
  output logic               cand_ready,
  output logic               seen_flag,
  output logic               new_flag,
  output logic [COUNT_W-1:0] count,
  output logic               done_sbox,
`ifdef SBOX_BUILDER_INV_EN
  input  logic [BYTE_W-1:0]  inv_rd_addr,
  output logic [BYTE_W-1:0]  inv_rd_data,
`endif
  input  logic [BYTE_W-1:0]  rd_addr,
  output logic [BYTE_W-1:0]  rd_data
);

  state_t               state;
  logic [SBOX_SIZE-1:0] bitmap;
  logic                 transfer;
  logic                 hit;
  logic                 wr_en;

  assign cand_ready = (state == COLLECT);
  // start outranks a coincident candidate, which is simply dropped
  assign transfer   = cand_valid && cand_ready && !start;
  assign hit        = bitmap[cand_byte];
  assign wr_en      = transfer && !hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      bitmap    <= '0;
      new_flag  <= 1'b0;
      seen_flag <= 1'b0;
      done_sbox <= 1'b0;
    end else begin
      new_flag  <= 1'b0;
      seen_flag <= 1'b0;
      if (start) begin
        state     <= COLLECT;
        count     <= '0;
        bitmap    <= '0;
        done_sbox <= 1'b0;
      end else begin
        case (state)
          COLLECT: begin
            if (transfer) begin
              if (hit) begin
                seen_flag <= 1'b1;
              end else begin
                bitmap[cand_byte] <= 1'b1;
                count             <= count + 1'b1;
                new_flag          <= 1'b1;
                if (count == COUNT_W'(SBOX_SIZE - 1)) begin
                  state     <= DONE;
                  done_sbox <= 1'b1;
                end
              end
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

  sbox_mem u_sbox (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wr_en),
    .wr_addr (count[BYTE_W-1:0]),
    .wr_data (cand_byte),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

`ifdef SBOX_BUILDER_INV_EN
  sbox_mem u_inv_sbox (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wr_en),
    .wr_addr (cand_byte),
    .wr_data (count[BYTE_W-1:0]),
    .rd_addr (inv_rd_addr),
    .rd_data (inv_rd_data)
  );
`endif

endmodule
